pattern_rom_arbiter: RTL
========================

# pattern_rom_arbiter

Shares one single-port synchronous pattern ROM (16-bit words, 1-cycle read latency) between several `pattern_sequencer` channels. Each cycle it grants at most one channel, muxes that channel's address to the ROM, and the next cycle routes the returned word back with a one-hot valid. It sits between the per-voice sequencers and the shared `rom_sync` instance in the multi-voice audio path.

## Interface
Parameters:
- `CHANNELS`, 4: number of requesting sequencers, 2..8.
- `DEPTH`, 256: ROM depth in words.
- `ADDRW` (localparam), `$clog2(DEPTH)`: ROM address width.

Ports:
- `i_clk`  in  1  system clock; all state on rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_req`  in  CHANNELS  per-channel read request, held until acked.
- `i_lock`  in  CHANNELS  per-channel burst lock, sampled with `i_req`.
- `i_addr`  in  CHANNELS*ADDRW  packed addresses; channel k at `[k*ADDRW +: ADDRW]`.
- `o_ack`  out  CHANNELS  one-hot: request accepted this cycle (combinational).
- `o_valid`  out  CHANNELS  one-hot: `o_data` belongs to this channel this cycle.
- `o_data`  out  16  read data, equal to `i_rom_data`.
- `o_rom_addr`  out  ADDRW  address to ROM.
- `i_rom_data`  in  16  ROM read data, valid one cycle after address.
- `o_busy`  out  1  high when any `o_ack` bit is high.

## Operation
- Requester protocol: raise `i_req[k]` with stable `i_addr[k]`; hold both until `o_ack[k]` is high. The request completes in the ack cycle. To read back-to-back, keep `i_req[k]` high and change the address after the ack edge.
- Grant selection is combinational from current inputs and registered state:
  - Lock rule: `lock_owner` is a registered channel index and `lock_vld` a registered flag. If `lock_vld` and `i_req[lock_owner]`, that channel wins.
  - Otherwise round-robin: search from `rr_ptr` upward with wrap, and pick the first channel with `i_req` high.
- On a grant to channel g at the clock edge:
  - `rr_ptr <= (g+1) mod CHANNELS`.
  - `lock_owner <= g`, `lock_vld <= i_lock[g]`.
  - `last_addr <= i_addr[g]`.
  - `resp_onehot <= 1<<g`.
- No grant: `resp_onehot <= 0`, `lock_vld <= 0`, and `rr_ptr` / `last_addr` are unchanged.
- `o_rom_addr` is `i_addr[g]` while a grant is active, otherwise `last_addr`. Idle cycles keep the address stable, which avoids ROM toggling.
- `o_valid = resp_onehot`; `o_data = i_rom_data`.
- A locked channel dropping `i_req` releases the lock in that cycle; normal round-robin applies immediately.
- `i_lock` on a non-granted channel has no effect.

## Timing
- Reset (async assert, sync-safe deassert handled upstream) sets:
  - `rr_ptr=0`, `lock_vld=0`, `lock_owner=0`, `last_addr=0`, `resp_onehot=0`.
  - Therefore `o_valid=0`, `o_rom_addr=0` (with no requests), `o_busy=0`.
- Latency: ack in cycle N, `o_valid[g]` and data in cycle N+1, fixed.
- Throughput: one read per cycle total. Each of C contending unlocked channels is served once every C cycles.
- Worst-case wait for an unlocked requester is `CHANNELS-1` grants, plus any lock burst in progress.
- Reset asserted mid-transaction: the pending `o_valid` is dropped and the lock is cleared. Requesters must re-issue.
- A request raised in the same cycle another channel's grant occurs is evaluated the following cycle.

## Configuration
- `PATTERN_ROM_ARB_LOCK_EN`:
  - Defined: lock rule as above.
  - Undefined: `i_lock` is ignored, `lock_vld` is held at 0, and arbitration is pure round-robin.

## Test plan
- Single requester: reset, `i_req=0001`, `i_addr[0]=5`, ROM[5]=16'hA1B2. Expect `o_ack=0001` and `o_rom_addr=5` in cycle N; `o_valid=0001`, `o_data=A1B2` in N+1; `o_busy=1` only in N.
- Full contention: all four request continuously with addresses 10..13. Expect grant order 0,1,2,3,0,… and `o_valid` one cycle behind with ROM[10..13].
- Lock burst (macro defined): ch1 requests with `i_lock=1` for 3 acks while ch0 and ch2 request. Expect acks 1,1,1, then 2,0 (ptr=2). With the macro undefined, expect 1,2,0,… interleaving.
- Idle hold: after a grant of addr 77, drop all requests. Expect `o_rom_addr=77` and `o_valid=0` for 10 idle cycles.
- Async reset mid-read: assert `i_rst_n=0` between ack and response. Expect `o_valid=0` immediately (no clock needed) and `o_rom_addr=0`. After release, the first grant goes to ch0 when all request.
- Wrap: `CHANNELS=4`, `rr_ptr=3`, requests on ch3 and ch0. Expect ch3 then ch0 (ptr wraps to 0).

Source files
------------

// File: rtl/pattern_rom_arbiter_if.sv
// Requester and ROM-side bus shared by pattern_rom_arbiter and its users.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface pattern_rom_arbiter_if #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DEPTH    = 256
);
  localparam int unsigned ADDRW = $clog2(DEPTH);

  logic [CHANNELS-1:0]       i_req;
  logic [CHANNELS-1:0]       i_lock;
  logic [CHANNELS*ADDRW-1:0] i_addr;
  logic [CHANNELS-1:0]       o_ack;
  logic [CHANNELS-1:0]       o_valid;
  logic [15:0]               o_data;
  logic [ADDRW-1:0]          o_rom_addr;
  logic [15:0]               i_rom_data;
  logic                      o_busy;

  modport slave (
    input  i_req, i_lock, i_addr, i_rom_data,
    output o_ack, o_valid, o_data, o_rom_addr, o_busy
  );

  modport master (
    output i_req, i_lock, i_addr, i_rom_data,
    input  o_ack, o_valid, o_data, o_rom_addr, o_busy
  );
endinterface

// File: rtl/pattern_rom_arbiter.sv
// Round-robin arbiter sharing one 1-cycle-latency pattern ROM between sequencer channels.
// Optional burst lock enabled by defining PATTERN_ROM_ARB_LOCK_EN.
module pattern_rom_arbiter #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DEPTH    = 256
) (
  input logic                   i_clk,
  input logic                   i_rst_n,
  pattern_rom_arbiter_if.slave  bus
);
  localparam int unsigned ADDRW = $clog2(DEPTH);
  localparam int unsigned CHW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHW-1:0]      r_rr_ptr;
  logic [ADDRW-1:0]    r_last_addr;
  logic [CHANNELS-1:0] r_resp_onehot;

  logic                w_gnt_vld;
  logic [CHW-1:0]      w_gnt_idx;
  logic [CHW-1:0]      w_ptr_nxt;
  logic [ADDRW-1:0]    w_sel_addr;

`ifdef PATTERN_ROM_ARB_LOCK_EN
  logic [CHW-1:0]      r_lock_owner;
  logic                r_lock_vld;
`else
  logic                w_unused_lock;
  assign w_unused_lock = ^bus.i_lock;
`endif

  // Grant: held lock owner first, otherwise first requester at or after rr_ptr.
  always_comb begin : grant_sel
    logic [CHW-1:0] cand;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    cand      = '0;
`ifdef PATTERN_ROM_ARB_LOCK_EN
    if (r_lock_vld && bus.i_req[r_lock_owner]) begin
      w_gnt_vld = 1'b1;
      w_gnt_idx = r_lock_owner;
    end
`endif
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      cand = CHW'((32'(r_rr_ptr) + i) % CHANNELS);
      if (!w_gnt_vld && bus.i_req[cand]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = cand;
      end
    end
  end

  assign w_ptr_nxt  = (32'(w_gnt_idx) == CHANNELS - 1) ? '0 : w_gnt_idx + CHW'(1);
  assign w_sel_addr = bus.i_addr[32'(w_gnt_idx) * ADDRW +: ADDRW];

  assign bus.o_ack      = CHANNELS'(w_gnt_vld) << w_gnt_idx;
  assign bus.o_busy     = w_gnt_vld;
  // Idle cycles replay the last address so the ROM input does not toggle.
  assign bus.o_rom_addr = w_gnt_vld ? w_sel_addr : r_last_addr;
  assign bus.o_valid    = r_resp_onehot;
  assign bus.o_data     = bus.i_rom_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rr_ptr      <= '0;
      r_last_addr   <= '0;
      r_resp_onehot <= '0;
    end else if (w_gnt_vld) begin
      r_rr_ptr      <= w_ptr_nxt;
      r_last_addr   <= w_sel_addr;
      r_resp_onehot <= CHANNELS'(1) << w_gnt_idx;
    end else begin
      r_resp_onehot <= '0;
    end
  end

`ifdef PATTERN_ROM_ARB_LOCK_EN
  // Lock follows the granted channel's i_lock; any idle cycle releases it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lock_owner <= '0;
      r_lock_vld   <= 1'b0;
    end else if (w_gnt_vld) begin
      r_lock_owner <= w_gnt_idx;
      r_lock_vld   <= bus.i_lock[w_gnt_idx];
    end else begin
      r_lock_vld   <= 1'b0;
    end
  end
`endif

endmodule
